// File: rtl/banzai_chip_pkg.sv
// Shared types and widths for the memristor chip master sequencer.
// Opcodes, FSM states and small opcode-classification helpers.
package banzai_chip_pkg;

    localparam int ADDR_W   = 8;
    localparam int SEED_W   = 8;
    localparam int BITOUT_W = 4;
    localparam int OP_W     = 3;

    typedef enum logic [OP_W-1:0] {
        OP_WRITE = 3'd0,
        OP_SEED  = 3'd1,
        OP_READ1 = 3'd2,
        OP_READ8 = 3'd3,
        OP_INFER = 3'd4
    } chip_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EXEC,
        ST_SAMPLE,
        ST_HOLD,
        ST_RESP,
        ST_ERR
    } seq_state_e;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op <= OP_INFER);
    endfunction

    // Ops that sample bit_out and therefore produce a response.
    function automatic logic op_has_sample(input logic [OP_W-1:0] op);
        return (op == OP_READ1) || (op == OP_READ8) || (op == OP_INFER);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/chip_phase_timer.sv
// Loadable down-counter shared by every sequencer phase.
// Saturates at zero; o_done is high whenever the count is zero.
module chip_phase_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/chip_sequencer.sv
// Command-driven master for the memristor inference chip: expands one
// high-level command into timed pin strobes and returns the bit_out nibble.
module chip_sequencer
    import banzai_chip_pkg::*;
#(
    parameter int SETUP_CYCLES = 2,
    parameter int PROG_CYCLES  = 16,
    parameter int INFER_CYCLES = 8,
    parameter int READ_LAT     = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OP_W-1:0]     cmd_op,
    input  logic [ADDR_W-1:0]   cmd_row,
    input  logic [ADDR_W-1:0]   cmd_col,
    input  logic [SEED_W-1:0]   cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [BITOUT_W-1:0] rsp_data,
    output logic [OP_W-1:0]     rsp_op,
    output logic                err_pulse,
    output logic                chip_clk,
    output logic                CBL,
    output logic                CBLEN,
    output logic                CWL,
    output logic                inference,
    output logic                load_seed,
    output logic                read_1,
    output logic                read_8,
    output logic                load_mem,
    output logic                read_out,
    output logic [ADDR_W-1:0]   addr_full_row,
    output logic [ADDR_W-1:0]   addr_full_col,
    output logic [SEED_W-1:0]   seeds,
    input  logic [BITOUT_W-1:0] bit_out
);

    localparam int MAX_LEN = max_int(max_int(max_int(SETUP_CYCLES, PROG_CYCLES),
                                             max_int(INFER_CYCLES, READ_LAT)),
                                     HOLD_CYCLES);
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_PROG  = CNT_W'(PROG_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_INFER = CNT_W'(INFER_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_READ  = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(HOLD_CYCLES - 1);

    seq_state_e          r_state;
    logic [OP_W-1:0]     r_op;
    logic                r_cmd_ready;
    logic                r_rsp_valid;
    logic [BITOUT_W-1:0] r_rsp_data;
    logic [OP_W-1:0]     r_rsp_op;
    logic                r_err_pulse;
    logic                r_chip_clk;
    logic                r_cbl;
    logic                r_cblen;
    logic                r_cwl;
    logic                r_load_mem;
    logic                r_load_seed;
    logic                r_read_1;
    logic                r_read_8;
    logic                r_inference;
    logic                r_read_out;
    logic [ADDR_W-1:0]   r_row;
    logic [ADDR_W-1:0]   r_col;
    logic [SEED_W-1:0]   r_seeds;

    logic                w_tmr_load;
    logic [CNT_W-1:0]    w_tmr_val;
    logic                w_tmr_done;

    // The timer reloads whenever a phase finishes, with the length of the
    // phase that follows; IDLE keeps it primed for SETUP.
    always_comb begin
        w_tmr_val = '0;
        case (r_state)
            ST_IDLE:   w_tmr_val = L_SETUP;
            ST_SETUP: begin
                if (r_op == OP_WRITE) begin
                    w_tmr_val = L_PROG;
                end else if (r_op == OP_INFER) begin
                    w_tmr_val = L_INFER;
                end else begin
                    w_tmr_val = '0;
                end
            end
            ST_EXEC:   w_tmr_val = op_has_sample(r_op) ? L_READ : L_HOLD;
            ST_SAMPLE: w_tmr_val = L_HOLD;
            default:   w_tmr_val = '0;
        endcase
    end

    assign w_tmr_load = w_tmr_done | (r_state == ST_IDLE);

    chip_phase_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_op    <= '0;
            r_err_pulse <= 1'b0;
            r_chip_clk  <= 1'b0;
            r_cbl       <= 1'b0;
            r_cblen     <= 1'b0;
            r_cwl       <= 1'b0;
            r_load_mem  <= 1'b0;
            r_load_seed <= 1'b0;
            r_read_1    <= 1'b0;
            r_read_8    <= 1'b0;
            r_inference <= 1'b0;
            r_read_out  <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
            r_seeds     <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_op        <= cmd_op;
                        r_cmd_ready <= 1'b0;
                        if (op_is_legal(cmd_op)) begin
                            r_state <= ST_SETUP;
                            r_row   <= cmd_row;
                            r_col   <= cmd_col;
                            r_seeds <= (cmd_op == OP_SEED) ? cmd_data : '0;
                            r_cbl   <= (cmd_op == OP_WRITE) ? cmd_data[0] : 1'b0;
                        end else begin
                            r_state     <= ST_ERR;
                            r_err_pulse <= 1'b1;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (w_tmr_done) begin
                        r_state    <= ST_EXEC;
                        r_chip_clk <= 1'b1;
                        case (r_op)
                            OP_WRITE: begin
                                r_load_mem <= 1'b1;
                                r_cblen    <= 1'b1;
                                r_cwl      <= 1'b1;
                            end
                            OP_SEED:  r_load_seed <= 1'b1;
                            OP_READ1: r_read_1    <= 1'b1;
                            OP_READ8: r_read_8    <= 1'b1;
                            default:  r_inference <= 1'b1;
                        endcase
                    end
                end
                ST_EXEC: begin
                    if (w_tmr_done) begin
                        r_load_mem  <= 1'b0;
                        r_cblen     <= 1'b0;
                        r_cwl       <= 1'b0;
                        r_load_seed <= 1'b0;
                        r_read_1    <= 1'b0;
                        r_read_8    <= 1'b0;
                        r_inference <= 1'b0;
                        if (op_has_sample(r_op)) begin
                            r_state    <= ST_SAMPLE;
                            r_read_out <= 1'b1;
                            r_chip_clk <= ~r_chip_clk;
                        end else begin
                            r_state    <= ST_HOLD;
                            r_chip_clk <= 1'b0;
                        end
                    end else begin
                        r_chip_clk <= ~r_chip_clk;
                    end
                end
                ST_SAMPLE: begin
                    if (w_tmr_done) begin
                        r_state    <= ST_HOLD;
                        r_read_out <= 1'b0;
                        r_rsp_data <= bit_out;
                        r_rsp_op   <= r_op;
                        r_chip_clk <= 1'b0;
                    end else begin
                        r_chip_clk <= ~r_chip_clk;
                    end
                end
                ST_HOLD: begin
                    if (w_tmr_done) begin
                        if (op_has_sample(r_op)) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_cmd_ready <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_ERR: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign rsp_op        = r_rsp_op;
    assign err_pulse     = r_err_pulse;
    assign chip_clk      = r_chip_clk;
    assign CBL           = r_cbl;
    assign CBLEN         = r_cblen;
    assign CWL           = r_cwl;
    assign inference     = r_inference;
    assign load_seed     = r_load_seed;
    assign read_1        = r_read_1;
    assign read_8        = r_read_8;
    assign load_mem      = r_load_mem;
    assign read_out      = r_read_out;
    assign addr_full_row = r_row;
    assign addr_full_col = r_col;
    assign seeds         = r_seeds;

endmodule

// File: tb/tb_chip_sequencer.sv
// Scoreboard bench for chip_sequencer: drives commands, checks pin timing
// cycle by cycle and matches responses against queued expectations.
module tb_chip_sequencer;
    import banzai_chip_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_row = 8'h00;
    logic [7:0] cmd_col = 8'h00;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_data;
    logic [2:0] rsp_op;
    logic       err_pulse;
    logic       chip_clk, CBL, CBLEN, CWL, inference, load_seed;
    logic       read_1, read_8, load_mem, read_out;
    logic [7:0] addr_full_row, addr_full_col, seeds;
    logic [3:0] bit_out = 4'h0;

    localparam logic [7:0] S_WRITE = 8'b1110_0000;
    localparam logic [7:0] S_SEED  = 8'b0001_0000;
    localparam logic [7:0] S_R1    = 8'b0000_1000;
    localparam logic [7:0] S_R8    = 8'b0000_0100;
    localparam logic [7:0] S_INF   = 8'b0000_0010;
    localparam logic [7:0] S_RO    = 8'b0000_0001;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] data;
    } rsp_t;

    rsp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    chip_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_row       (cmd_row),
        .cmd_col       (cmd_col),
        .cmd_data      (cmd_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_op        (rsp_op),
        .err_pulse     (err_pulse),
        .chip_clk      (chip_clk),
        .CBL           (CBL),
        .CBLEN         (CBLEN),
        .CWL           (CWL),
        .inference     (inference),
        .load_seed     (load_seed),
        .read_1        (read_1),
        .read_8        (read_8),
        .load_mem      (load_mem),
        .read_out      (read_out),
        .addr_full_row (addr_full_row),
        .addr_full_col (addr_full_col),
        .seeds         (seeds),
        .bit_out       (bit_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at cyc %0d", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] strobes();
        return {CBLEN, CWL, load_mem, load_seed, read_1, read_8, inference, read_out};
    endfunction

    // Returns at the sampling point of cycle T+1, with cmd_valid already dropped.
    task automatic issue(input logic [2:0] op, input logic [7:0] row, input logic [7:0] col,
                         input logic [7:0] data, input logic [3:0] nib, output int t);
        int   waited = 0;
        rsp_t e;
        while (!cmd_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("issue_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_row   = row;
        cmd_col   = col;
        cmd_data  = data;
        t         = cyc;
        if (op_has_sample(op)) begin
            e.op   = op;
            e.data = nib;
            sb_q.push_back(e);
        end
        $display("TXN issue op=%0d row=0x%02h col=0x%02h data=0x%02h T=%0d", op, row, col, data, t);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic collect_rsp();
        int   waited = 0;
        rsp_t e;
        while (!rsp_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("rsp_arrived", 32'(rsp_valid), 1);
        check("sb_pending", 32'(sb_q.size() > 0), 1);
        if (rsp_valid && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("rsp_data", 32'(rsp_data), 32'(e.data));
            check("rsp_op", 32'(rsp_op), 32'(e.op));
            $display("TXN rsp op=%0d data=0x%0h cyc=%0d", rsp_op, rsp_data, cyc);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check("rsp_valid_drop", 32'(rsp_valid), 0);
            check("rsp_cmd_ready", 32'(cmd_ready), 1);
        end
    endtask

    task automatic run_read(input logic [2:0] op, input logic [7:0] row, input logic [7:0] col,
                            input logic [3:0] nib);
        int         t;
        logic [7:0] exp_s;
        bit_out = nib;
        issue(op, row, col, 8'h00, nib, t);
        for (int k = 1; k <= 7; k++) begin
            exp_s = 8'h00;
            if (k == 3) exp_s = (op == OP_READ1) ? S_R1 : S_R8;
            if (k == 4 || k == 5) exp_s = S_RO;
            check("rd_strobes", 32'(strobes()), 32'(exp_s));
            check("rd_rsp_valid", 32'(rsp_valid), 32'(k == 7));
            if (k == 1) begin
                check("rd_row", 32'(addr_full_row), 32'(row));
                check("rd_col", 32'(addr_full_col), 32'(col));
            end
            if (k < 7) @(negedge clk);
        end
        collect_rsp();
    endtask

    initial begin
        int         t;
        int         n_prog;
        logic [7:0] exp_s;
        logic       exp_ck;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_strobes", 32'(strobes()), 0);
        check("rst_misc", 32'({rsp_valid, err_pulse, chip_clk, CBL}), 0);
        check("rst_buses", 32'({addr_full_row, addr_full_col, seeds}), 0);
        check("rst_rsp", 32'({rsp_data, rsp_op}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_rise", 32'(cmd_ready), 1);

        // Basic single-bit read
        run_read(OP_READ1, 8'h12, 8'h34, 4'hA);

        // Programming pulse
        n_prog = 0;
        issue(OP_WRITE, 8'h03, 8'h05, 8'h01, 4'h0, t);
        for (int k = 1; k <= 20; k++) begin
            exp_s  = (k >= 3 && k <= 18) ? S_WRITE : 8'h00;
            exp_ck = (k >= 3 && k <= 18) ? ((k - 3) % 2 == 0) : 1'b0;
            if (load_mem) n_prog++;
            check("wr_strobes", 32'(strobes()), 32'(exp_s));
            check("wr_chip_clk", 32'(chip_clk), 32'(exp_ck));
            check("wr_cbl", 32'(CBL), 1);
            check("wr_rsp_valid", 32'(rsp_valid), 0);
            check("wr_cmd_ready", 32'(cmd_ready), 32'(k == 20));
            if (k == 1) check("wr_addr", 32'({addr_full_row, addr_full_col}), 32'h0305);
            if (k < 20) @(negedge clk);
        end
        check("wr_prog_len", n_prog, 16);

        // Seed load
        issue(OP_SEED, 8'h00, 8'h00, 8'hC3, 4'h0, t);
        for (int k = 1; k <= 6; k++) begin
            check("seed_strobes", 32'(strobes()), 32'((k == 3) ? S_SEED : 8'h00));
            check("seed_bus", 32'(seeds), 32'hC3);
            check("seed_cmd_ready", 32'(cmd_ready), 32'(k >= 5));
            check("seed_rsp_valid", 32'(rsp_valid), 0);
            if (k < 6) @(negedge clk);
        end

        // Inference with a stalled consumer and a command offered while busy
        bit_out = 4'h5;
        issue(OP_INFER, 8'h40, 8'h41, 8'h00, 4'h5, t);
        for (int k = 1; k <= 17; k++) begin
            exp_s = 8'h00;
            if (k >= 3 && k <= 10) exp_s = S_INF;
            if (k == 11 || k == 12) exp_s = S_RO;
            exp_ck = (k >= 3 && k <= 12) ? ((k - 3) % 2 == 0) : 1'b0;
            check("inf_strobes", 32'(strobes()), 32'(exp_s));
            check("inf_chip_clk", 32'(chip_clk), 32'(exp_ck));
            check("inf_rsp_valid", 32'(rsp_valid), 32'(k >= 14));
            check("inf_cmd_ready", 32'(cmd_ready), 0);
            check("inf_row_kept", 32'(addr_full_row), 32'h40);
            if (k >= 14) check("inf_rsp_hold", 32'(rsp_data), 32'h5);
            if (k == 1) begin
                cmd_valid = 1'b1;
                cmd_op    = OP_READ8;
                cmd_row   = 8'hEE;
                cmd_col   = 8'hEF;
            end
            if (k < 17) @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        bit_out   = 4'hF;
        collect_rsp();
        check("inf_no_accept", 32'(strobes()), 0);

        // Asynchronous reset during programming
        issue(OP_WRITE, 8'h07, 8'h08, 8'h01, 4'h0, t);
        repeat (9) @(negedge clk);
        check("rstm_prog_active", 32'(load_mem), 1);
        rst_n = 1'b0;
        #1;
        check("rstm_strobes", 32'(strobes()), 0);
        check("rstm_misc", 32'({CBL, chip_clk, rsp_valid, cmd_ready}), 0);
        repeat (2) @(negedge clk);
        check("rstm_rsp_valid", 32'(rsp_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstm_ready", 32'(cmd_ready), 1);
        run_read(OP_READ1, 8'h21, 8'h22, 4'h3);

        // Illegal opcode
        issue(3'd6, 8'h99, 8'h98, 8'hFF, 4'h0, t);
        for (int k = 1; k <= 3; k++) begin
            check("ill_err_pulse", 32'(err_pulse), 32'(k == 1));
            check("ill_cmd_ready", 32'(cmd_ready), 32'(k >= 2));
            check("ill_strobes", 32'(strobes()), 0);
            check("ill_chip_clk", 32'(chip_clk), 0);
            check("ill_rsp_valid", 32'(rsp_valid), 0);
            check("ill_row_kept", 32'(addr_full_row), 32'h21);
            if (k < 3) @(negedge clk);
        end

        // Eight-bit read path
        run_read(OP_READ8, 8'hA5, 8'h5A, 4'h9);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
